// File: rtl/data_mem_dp.sv
// Dual-port data memory: port A read/write, port B read-only, with a sequential clear walk.
// Optional macro DMEM_PRELOAD_EN adds a 4-entry constant preload after every clear.
module data_mem_dp #(
   parameter int W = 8,
   parameter int A = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         ClearReq,
   input  logic         WriteEnA,
   input  logic [A-1:0] DataAddressA,
   input  logic [W-1:0] DataInA,
   output logic [W-1:0] DataOutA,
   input  logic [A-1:0] DataAddressB,
   output logic [W-1:0] DataOutB,
   output logic         Busy,
   output logic         WrDropped
);

   localparam int DEPTH = 2**A;

`ifdef DMEM_PRELOAD_EN
   typedef enum logic [1:0] {S_CLEAR = 2'd0, S_PRELOAD = 2'd1, S_READY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_CLEAR = 2'd0, S_READY = 2'd2} state_t;
`endif

   state_t       r_state, w_state_nxt;
   logic [A-1:0] r_ptr, w_ptr_nxt;
   logic         r_wr_dropped;
   logic [W-1:0] r_core [DEPTH];

   logic         w_busy;
   logic         w_we;
   logic [A-1:0] w_waddr;
   logic [W-1:0] w_wdata;

`ifdef DMEM_PRELOAD_EN
   logic [1:0]  r_pre_idx, w_pre_idx_nxt;
   logic [31:0] w_pre_addr;
   logic [31:0] w_pre_val;

   always_comb begin
      w_pre_addr = 32'd244;
      w_pre_val  = 32'd5;
      case (r_pre_idx)
         2'd0:    begin w_pre_addr = 32'd0;  w_pre_val = 32'd16;  end
         2'd1:    begin w_pre_addr = 32'd4;  w_pre_val = 32'd24;  end
         2'd2:    begin w_pre_addr = 32'd16; w_pre_val = 32'd254; end
         default: begin w_pre_addr = 32'd244; w_pre_val = 32'd5;  end
      endcase
   end
`endif

   assign w_busy = (r_state != S_READY);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_we        = 1'b0;
      w_waddr     = r_ptr;
      w_wdata     = '0;
`ifdef DMEM_PRELOAD_EN
      w_pre_idx_nxt = r_pre_idx;
`endif
      case (r_state)
         S_CLEAR: begin
            w_we      = 1'b1;
            w_ptr_nxt = r_ptr + A'(1);
            if (r_ptr == '1) begin
`ifdef DMEM_PRELOAD_EN
               w_state_nxt = S_PRELOAD;
`else
               w_state_nxt = S_READY;
`endif
            end
         end
`ifdef DMEM_PRELOAD_EN
         S_PRELOAD: begin
            // Out-of-range entries still take their slot so preload length is fixed.
            w_we          = (w_pre_addr < 32'(DEPTH));
            w_waddr       = A'(w_pre_addr);
            w_wdata       = W'(w_pre_val);
            w_pre_idx_nxt = r_pre_idx + 2'd1;
            if (r_pre_idx == 2'd3) w_state_nxt = S_READY;
         end
`endif
         default: begin
            w_we    = WriteEnA;
            w_waddr = DataAddressA;
            w_wdata = DataInA;
            if (ClearReq) begin
               w_state_nxt = S_CLEAR;
               w_ptr_nxt   = '0;
            end
         end
      endcase
      if (Reset) w_we = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= S_CLEAR;
         r_ptr        <= '0;
         r_wr_dropped <= 1'b0;
`ifdef DMEM_PRELOAD_EN
         r_pre_idx    <= 2'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
`ifdef DMEM_PRELOAD_EN
         r_pre_idx <= w_pre_idx_nxt;
`endif
         if (w_busy && WriteEnA) r_wr_dropped <= 1'b1;
      end
   end

   // NOTE: the array has no reset branch; the clear walk initialises it so it maps onto RAM.
   always_ff @(posedge Clk) begin
      if (w_we) r_core[w_waddr] <= w_wdata;
   end

   assign DataOutA  = w_busy ? '0 : r_core[DataAddressA];
   assign DataOutB  = w_busy ? '0 : r_core[DataAddressB];
   assign Busy      = w_busy;
   assign WrDropped = r_wr_dropped;

endmodule

// File: tb/tb_data_mem_dp.sv
// Directed self-checking bench for data_mem_dp; A=8 by default, A=4 when DMEM_PRELOAD_EN is defined.
module tb_data_mem_dp;

`ifdef DMEM_PRELOAD_EN
   localparam int TB_A = 4;
`else
   localparam int TB_A = 8;
`endif
   localparam int TB_W = 8;

   logic            Clk = 1'b0;
   logic            Reset;
   logic            ClearReq;
   logic            WriteEnA;
   logic [TB_A-1:0] DataAddressA;
   logic [TB_W-1:0] DataInA;
   logic [TB_W-1:0] DataOutA;
   logic [TB_A-1:0] DataAddressB;
   logic [TB_W-1:0] DataOutB;
   logic            Busy;
   logic            WrDropped;

   int n_cmp = 0;
   int n_err = 0;

   data_mem_dp #(.W(TB_W), .A(TB_A)) dut (
      .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq), .WriteEnA(WriteEnA),
      .DataAddressA(DataAddressA), .DataInA(DataInA), .DataOutA(DataOutA),
      .DataAddressB(DataAddressB), .DataOutB(DataOutB),
      .Busy(Busy), .WrDropped(WrDropped)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Counts edges until Busy drops, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic read_both(input logic [TB_A-1:0] addr);
      DataAddressA = addr;
      DataAddressB = addr;
      #1;
   endtask

   task automatic test_reset();
      int n;
      Reset = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (Busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", Busy); end
      n_cmp++;
      if (WrDropped !== 1'b0) begin n_err++; $display("FAIL reset_wrdropped: got %b want 0", WrDropped); end
      n_cmp++;
      if (DataOutA !== '0 || DataOutB !== '0) begin
         n_err++; $display("FAIL reset_outputs: got A=%h B=%h want 00/00", DataOutA, DataOutB);
      end
      Reset = 1'b0;
      wait_ready(n);
      n_cmp++;
      if (n != (2**TB_A) + 0) begin n_err++; $display("FAIL reset_clear_len: got %0d edges want %0d", n, 2**TB_A); end
   endtask

`ifndef DMEM_PRELOAD_EN
   task automatic test_clear_contents();
      logic [7:0] addrs [3] = '{8'd0, 8'd127, 8'd255};
      foreach (addrs[i]) begin
         read_both(addrs[i]);
         n_cmp++;
         if (DataOutA !== 8'h00 || DataOutB !== 8'h00) begin
            n_err++; $display("FAIL clear_read[%0d]: got A=%h B=%h want 00", addrs[i], DataOutA, DataOutB);
         end
      end
   endtask

   task automatic test_write_read();
      DataAddressA = 8'h10; DataAddressB = 8'h10; DataInA = 8'hA5; WriteEnA = 1'b1;
      #1;
      n_cmp++;
      if (DataOutA !== 8'h00 || DataOutB !== 8'h00) begin
         n_err++; $display("FAIL rdw_old: got A=%h B=%h want 00", DataOutA, DataOutB);
      end
      tick();
      WriteEnA = 1'b0;
      #1;
      n_cmp++;
      if (DataOutA !== 8'hA5 || DataOutB !== 8'hA5) begin
         n_err++; $display("FAIL rdw_new: got A=%h B=%h want a5", DataOutA, DataOutB);
      end
      // Independent addresses on the two ports
      DataAddressA = 8'h20; DataInA = 8'h3C; WriteEnA = 1'b1;
      tick();
      WriteEnA = 1'b0;
      DataAddressB = 8'h10;
      #1;
      n_cmp++;
      if (DataOutA !== 8'h3C || DataOutB !== 8'hA5) begin
         n_err++; $display("FAIL two_ports: got A=%h B=%h want 3c/a5", DataOutA, DataOutB);
      end
      n_cmp++;
      if (WrDropped !== 1'b0) begin n_err++; $display("FAIL ready_no_drop: got %b want 0", WrDropped); end
   endtask

   task automatic test_dropped_write();
      int n;
      ClearReq = 1'b1;
      tick();
      ClearReq = 1'b0;
      n_cmp++;
      if (Busy !== 1'b1) begin n_err++; $display("FAIL runclr_busy: got %b want 1", Busy); end
      read_both(8'h10);
      n_cmp++;
      if (DataOutA !== 8'h00 || DataOutB !== 8'h00) begin
         n_err++; $display("FAIL busy_forced_zero: got A=%h B=%h want 00", DataOutA, DataOutB);
      end
      DataAddressA = 8'd3; DataInA = 8'h77; WriteEnA = 1'b1;
      tick();
      WriteEnA = 1'b0;
      n_cmp++;
      if (WrDropped !== 1'b1) begin n_err++; $display("FAIL wrdropped_set: got %b want 1", WrDropped); end
      wait_ready(n);
      n_cmp++;
      if (n != 255) begin n_err++; $display("FAIL runclr_len: got %0d remaining edges want 255", n); end
      read_both(8'd3);
      n_cmp++;
      if (DataOutA !== 8'h00) begin n_err++; $display("FAIL dropped_addr3: got %h want 00", DataOutA); end
      n_cmp++;
      if (DataOutB !== 8'h00) begin n_err++; $display("FAIL cleared_0x10: got %h want 00", DataOutB); end
      n_cmp++;
      if (WrDropped !== 1'b1) begin n_err++; $display("FAIL wrdropped_sticky: got %b want 1", WrDropped); end
   endtask

   task automatic test_clear_req();
      int n;
      for (int i = 0; i < 4; i++) begin
         DataAddressA = 8'(i); DataInA = 8'hFF; WriteEnA = 1'b1;
         tick();
      end
      WriteEnA = 1'b0;
      DataAddressB = 8'd2;
      #1;
      n_cmp++;
      if (DataOutB !== 8'hFF) begin n_err++; $display("FAIL fill_ff: got %h want ff", DataOutB); end
      ClearReq = 1'b1; WriteEnA = 1'b1; DataAddressA = 8'd5; DataInA = 8'h11;
      #1;
      n_cmp++;
      if (Busy !== 1'b0) begin n_err++; $display("FAIL clrreq_busy_pre: got %b want 0", Busy); end
      tick();
      ClearReq = 1'b0; WriteEnA = 1'b0;
      n_cmp++;
      if (Busy !== 1'b1) begin n_err++; $display("FAIL clrreq_busy_post: got %b want 1", Busy); end
      // A request in the middle of the walk must not restart it
      n = 0;
      repeat (50) begin tick(); n++; end
      ClearReq = 1'b1;
      tick(); n++;
      ClearReq = 1'b0;
      begin
         int m;
         wait_ready(m);
         n += m;
      end
      n_cmp++;
      if (n != 256) begin n_err++; $display("FAIL clrreq_len: got %0d edges want 256", n); end
      for (int i = 0; i < 6; i++) begin
         if (i == 4) continue;
         read_both(8'(i));
         n_cmp++;
         if (DataOutA !== 8'h00 || DataOutB !== 8'h00) begin
            n_err++; $display("FAIL clrreq_read[%0d]: got A=%h B=%h want 00", i, DataOutA, DataOutB);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      DataAddressA = 8'd200; DataInA = 8'h5A; WriteEnA = 1'b1;
      tick();
      WriteEnA = 1'b0;
      ClearReq = 1'b1;
      tick();
      ClearReq = 1'b0;
      repeat (100) tick();
      Reset = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if (Busy !== 1'b1 || WrDropped !== 1'b0) begin
         n_err++; $display("FAIL midreset_state: got Busy=%b WrDropped=%b want 1/0", Busy, WrDropped);
      end
      Reset = 1'b0;
      wait_ready(n);
      n_cmp++;
      if (n != 256) begin n_err++; $display("FAIL midreset_len: got %0d edges want 256", n); end
      read_both(8'd200);
      n_cmp++;
      if (DataOutA !== 8'h00) begin n_err++; $display("FAIL midreset_read200: got %h want 00", DataOutA); end
   endtask
`else
   task automatic test_preload();
      logic [7:0] exp;
      for (int i = 0; i < 16; i++) begin
         exp = (i == 0) ? 8'd16 : (i == 4) ? 8'd24 : 8'd0;
         read_both(4'(i));
         n_cmp++;
         if (DataOutA !== exp || DataOutB !== exp) begin
            n_err++; $display("FAIL preload_read[%0d]: got A=%h B=%h want %h", i, DataOutA, DataOutB, exp);
         end
      end
   endtask

   task automatic test_preload_runtime();
      int n;
      DataAddressA = 4'd0; DataInA = 8'h99; WriteEnA = 1'b1;
      tick();
      WriteEnA = 1'b0;
      ClearReq = 1'b1;
      tick();
      ClearReq = 1'b0;
      wait_ready(n);
      n_cmp++;
      if (n != 20) begin n_err++; $display("FAIL preload_runclr_len: got %0d edges want 20", n); end
      read_both(4'd0);
      n_cmp++;
      if (DataOutA !== 8'd16) begin n_err++; $display("FAIL preload_runclr_addr0: got %h want 10", DataOutA); end
   endtask
`endif

   initial begin
      Reset = 1'b1; ClearReq = 1'b0; WriteEnA = 1'b0;
      DataAddressA = '0; DataAddressB = '0; DataInA = '0;
`ifdef DMEM_PRELOAD_EN
      // With preload the walk is DEPTH + 4 edges
      begin
         int n;
         Reset = 1'b1;
         repeat (3) tick();
         n_cmp++;
         if (Busy !== 1'b1 || WrDropped !== 1'b0 || DataOutA !== '0) begin
            n_err++; $display("FAIL reset_state: got Busy=%b WrDropped=%b A=%h", Busy, WrDropped, DataOutA);
         end
         Reset = 1'b0;
         wait_ready(n);
         n_cmp++;
         if (n != 20) begin n_err++; $display("FAIL preload_len: got %0d edges want 20", n); end
      end
      test_preload();
      test_preload_runtime();
`else
      test_reset();
      test_clear_contents();
      test_write_read();
      test_dropped_write();
      test_clear_req();
      test_reset_mid_clear();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_dp.md
# data_mem_dp

Parametrised dual-port data memory for the single-cycle core: one read/write port (A) driven from the register file, plus an independent read-only port (B) for a second operand or debug tap. Replaces the single-cycle reset loop with a sequential clear engine that walks the array one word per cycle, so depth can scale without a giant reset fan-out. An optional preload phase plants fixed constants after clear.

## Interface
- W, 8, data width in bits
- A, 8, address width; DEPTH = 2**A words
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; starts the clear sequence
- ClearReq  in  1  runtime clear request; honoured only in READY
- WriteEnA  in  1  port A write enable
- DataAddressA  in  A  port A address (read and write)
- DataInA  in  W  port A write data
- DataOutA  out  W  port A combinational read data
- DataAddressB  in  A  port B read address
- DataOutB  out  W  port B combinational read data
- Busy  out  1  high while in CLEAR or PRELOAD
- WrDropped  out  1  sticky: a write was attempted while Busy

## Operation
- States: CLEAR, PRELOAD (only with macro), READY.
- Reset high: state <= CLEAR, ptr <= 0, WrDropped <= 0; no array writes while Reset high.
- CLEAR (Reset low): each edge writes Core[ptr] <= 0, ptr <= ptr+1. Edge writing ptr == DEPTH-1 moves to PRELOAD (macro) or READY; ptr wraps to 0.
- READY: WriteEnA high -> Core[DataAddressA] <= DataInA at edge. ClearReq high -> state <= CLEAR, ptr <= 0 at edge; a WriteEnA in that same cycle still completes (then gets cleared).
- ClearReq ignored in CLEAR/PRELOAD; does not restart the walk.
- WriteEnA high while Busy: write dropped, WrDropped <= 1. WrDropped cleared only by Reset.
- Reads: DataOutA = Core[DataAddressA], DataOutB = Core[DataAddressB] in READY; both forced to 0 while Busy.
- Same-address read-during-write (either port): output shows old word until the edge, new word after.
- Both ports may address the same word simultaneously; no arbitration needed.

## Timing
- Write latency 1 edge; read latency 0 (combinational).
- Reset values: Busy = 1, WrDropped = 0, DataOutA = DataOutB = 0.
- After Reset falls, Busy stays high for exactly DEPTH edges (+4 with preload); Busy low after the edge that completes the last write. DEPTH=256, no preload: edge 1 writes addr 0, edge 256 writes addr 255, READY from then on.
- Runtime clear: Busy rises the edge after ClearReq is sampled; same duration as above.
- Reset asserted mid-CLEAR/PRELOAD: ptr returns to 0, walk restarts from address 0 after Reset falls; partially cleared contents irrelevant since every word is rewritten.

## Configuration
- DMEM_PRELOAD_EN defined: after CLEAR, PRELOAD runs exactly 4 edges writing in order Core[0]=16, Core[4]=24, Core[16]=254, Core[244]=5 (values truncated to W bits). Entries with address >= DEPTH consume their cycle but are not written. Then READY. Preload also follows every runtime clear.
- Not defined: PRELOAD state absent; CLEAR goes straight to READY; memory all-zero after clear.

## Test plan
- Reset 3 cycles, release, W=8 A=8 no macro: Busy high exactly 256 edges, then low; DataOutA/B read 0 at addresses 0, 127, 255.
- READY, write 0xA5 to addr 0x10, read same addr on A and B in same cycle -> old value 0 before edge, 0xA5 on both ports after.
- WriteEnA=1 during CLEAR (addr 3, data 0x77) -> WrDropped=1, addr 3 reads 0 after READY; WrDropped stays 1 until Reset.
- Fill addrs 0..3 with 0xFF, pulse ClearReq together with write 0x11 to addr 5 -> Busy next edge, after 256 edges all five addrs read 0.
- Reset asserted at ptr=100 mid-clear -> Busy stays high, walk restarts at 0, full 256 edges after Reset falls.
- DMEM_PRELOAD_EN, A=4 (DEPTH 16): Busy 20 edges; reads addr 0=16, 4=24, all others 0 (16 and 244 out of range, not written).
